timepulse_monitor: RTL

TIMEPULSE_MONITOR -- requirements
Module: timepulse_monitor

---
 rtl/timepulse_monitor.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/timepulse_monitor.sv
// Time-pulse sequence monitor: locks onto the T01..T12 ring sampled on PSTB,
// counts memory cycles and sequence errors, and requests a restart on repeated faults.
module timepulse_monitor #(
  parameter int unsigned ERR_THRESH = 3,
  parameter int unsigned WDOG_LIMIT = 64
) (
  input  logic        CLOCK,
  input  logic        SIM_RST,
  input  logic [11:0] TPULSE,
  input  logic        PSTB,
  input  logic        GOJAM,
  input  logic        ALARM_CLR,
  output logic        IN_SYNC,
  output logic [3:0]  CUR_T,
  output logic [15:0] MCT_COUNT,
  output logic [3:0]  ERR_COUNT,
  output logic        TP_ALARM,
  output logic        GOJ1_REQ,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    LOCKED = 2'd1,
    ALARM  = 2'd2
  } state_t;

  localparam logic [3:0] THRESH = 4'(ERR_THRESH);
  localparam logic [7:0] WLIM   = 8'(WDOG_LIMIT);

  state_t      state_q, state_d;
  logic [3:0]  exp_q, exp_d;
  logic [3:0]  cur_q, cur_d;
  logic [15:0] mct_q, mct_d;
  logic [3:0]  consec_q, consec_d;
  logic [7:0]  wdog_q, wdog_d;
  logic [3:0]  errc_q, errc_d, errc_base;
  logic        alarm_q, alarm_d;
  logic        goj_q, goj_d;
  logic        in_sync_q;
  logic        err_ev;
  logic [3:0]  consec_inc;
  logic [3:0]  tp_idx;
  logic        tp_valid;

  always_comb begin
    tp_idx = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (TPULSE[i]) tp_idx = 4'(i + 1);
    end
    tp_valid = $onehot(TPULSE);
  end

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    cur_d      = cur_q;
    mct_d      = mct_q;
    consec_d   = consec_q;
    wdog_d     = wdog_q;
    goj_d      = 1'b0;
    err_ev     = 1'b0;
    consec_inc = (consec_q == 4'd15) ? 4'd15 : consec_q + 4'd1;

    if (GOJAM) begin
      // Restart wins over everything; the sample on this cycle is discarded.
      state_d  = SYNC;
      consec_d = 4'd0;
      wdog_d   = 8'd0;
      cur_d    = 4'd0;
    end else begin
      case (state_q)
        SYNC: begin
          wdog_d = 8'd0;
          if (PSTB && TPULSE == 12'h800) begin
            state_d = LOCKED;
            exp_d   = 4'd1;
            cur_d   = 4'd12;
          end
        end
        LOCKED: begin
          if (PSTB) begin
            wdog_d = 8'd0;
            if (tp_valid && tp_idx == exp_q) begin
              cur_d    = exp_q;
              exp_d    = (exp_q == 4'd12) ? 4'd1 : exp_q + 4'd1;
              consec_d = 4'd0;
              if (exp_q == 4'd12) mct_d = mct_q + 16'd1;
            end else begin
              err_ev = 1'b1;
              if (tp_valid) begin
                // A clean but out-of-order pulse re-anchors the sequence there.
                cur_d = tp_idx;
                exp_d = (tp_idx == 4'd12) ? 4'd1 : tp_idx + 4'd1;
              end else begin
                state_d = SYNC;
                cur_d   = 4'd0;
              end
            end
          end else if (wdog_q + 8'd1 == WLIM) begin
            err_ev  = 1'b1;
            wdog_d  = 8'd0;
            state_d = SYNC;
            cur_d   = 4'd0;
          end else begin
            wdog_d = wdog_q + 8'd1;
          end
        end
        default: begin
          cur_d = 4'd0;
        end
      endcase

      if (err_ev) begin
        consec_d = consec_inc;
        if (consec_inc >= THRESH) begin
          state_d = ALARM;
          cur_d   = 4'd0;
          goj_d   = 1'b1;
        end
      end
    end

    // Clear is applied before a coincident error is counted.
    errc_base = ALARM_CLR ? 4'd0 : errc_q;
    errc_d    = (err_ev && errc_base != 4'd15) ? errc_base + 4'd1 : errc_base;
    alarm_d   = (ALARM_CLR ? 1'b0 : alarm_q) | err_ev;
  end

  always_ff @(posedge CLOCK) begin
    if (!SIM_RST) begin
      state_q   <= SYNC;
      exp_q     <= 4'd0;
      cur_q     <= 4'd0;
      mct_q     <= 16'd0;
      consec_q  <= 4'd0;
      wdog_q    <= 8'd0;
      errc_q    <= 4'd0;
      alarm_q   <= 1'b0;
      goj_q     <= 1'b0;
      in_sync_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      cur_q     <= cur_d;
      mct_q     <= mct_d;
      consec_q  <= consec_d;
      wdog_q    <= wdog_d;
      errc_q    <= errc_d;
      alarm_q   <= alarm_d;
      goj_q     <= goj_d;
      in_sync_q <= (state_d == LOCKED);
    end
  end

  assign IN_SYNC   = in_sync_q;
  assign CUR_T     = cur_q;
  assign MCT_COUNT = mct_q;
  assign ERR_COUNT = errc_q;
  assign TP_ALARM  = alarm_q;
  assign GOJ1_REQ  = goj_q;
  assign dbg_state = state_q;

endmodule
